rv_issue_scoreboard: RTL

- Issue-stage controller between the RV32 decoder and the execute pipeline.
- Tracks outstanding register writes with per-register pending counters and stalls decoded instructions on RAW/WAW hazards.
- Serializes FENCE, FENCE.I, ECALL, EBREAK and CSR instructions by draining all in-flight writes.
- Raises a one-cycle instruction-fetch flush request after FENCE.I issues.

---
 rtl/rv_issue_scoreboard.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rv_issue_scoreboard.sv
// Issue-stage scoreboard: per-register pending-write counters, RAW/WAW stalls,
// drain-based serialization and a one-cycle fetch flush after FENCE.I.
module rv_issue_scoreboard #(
    parameter int PEND_WIDTH     = 2,
    parameter int INFLIGHT_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dec_valid,
    output logic                      dec_ready,
    input  logic [4:0]                dec_rs1,
    input  logic [4:0]                dec_rs2,
    input  logic [4:0]                dec_rd,
    input  logic                      dec_uses_rs1,
    input  logic                      dec_uses_rs2,
    input  logic                      dec_writes_rd,
    input  logic                      dec_serialize,
    input  logic                      dec_fence_i,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    input  logic                      wb_valid,
    input  logic [4:0]                wb_rd,
    output logic [INFLIGHT_WIDTH-1:0] inflight_count,
    output logic                      fence_i_flush,
    output logic                      err_underflow
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SERIAL,
        ST_FLUSH
    } state_t;

    localparam logic [PEND_WIDTH-1:0]     PEND_MAX = '1;
    localparam logic [INFLIGHT_WIDTH-1:0] INF_MAX  = '1;

    state_t                    r_state;
    logic [PEND_WIDTH-1:0]     r_pending [32];
    logic [INFLIGHT_WIDTH-1:0] r_inflight;
    logic                      r_flush;
    logic                      r_err;

    logic w_raw;
    logic w_waw_sat;
    logic w_inf_sat;
    logic w_ser_block;
    logic w_can_issue;
    logic w_fire;
    logic w_inc;
    logic w_dec_req;
    logic w_same;
    logic w_dec_ok;
    logic w_underflow;

    // Hazards look only at registered counters; a same-cycle writeback does not unblock.
    assign w_raw = (dec_uses_rs1 && (dec_rs1 != 5'd0) && (r_pending[dec_rs1] != '0)) ||
                   (dec_uses_rs2 && (dec_rs2 != 5'd0) && (r_pending[dec_rs2] != '0));
    assign w_waw_sat   = dec_writes_rd && (dec_rd != 5'd0) && (r_pending[dec_rd] == PEND_MAX);
    assign w_inf_sat   = dec_writes_rd && (dec_rd != 5'd0) && (r_inflight == INF_MAX);
    assign w_ser_block = (dec_serialize || dec_fence_i) && (r_inflight != '0);
    assign w_can_issue = (r_state == ST_RUN) && !w_raw && !w_waw_sat && !w_inf_sat && !w_ser_block;

    assign issue_valid = rst_n && dec_valid && w_can_issue;
    assign dec_ready   = rst_n && issue_ready && w_can_issue;
    assign w_fire      = dec_valid && dec_ready;

    // A same-register issue and writeback cancel out, so neither counter moves.
    assign w_inc       = w_fire && dec_writes_rd && (dec_rd != 5'd0);
    assign w_dec_req   = wb_valid && (wb_rd != 5'd0);
    assign w_same      = w_inc && w_dec_req && (dec_rd == wb_rd);
    assign w_dec_ok    = w_dec_req && !w_same && (r_pending[wb_rd] != '0);
    assign w_underflow = w_dec_req && !w_same && (r_pending[wb_rd] == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_pending[i] <= '0;
            end
            r_inflight <= '0;
            r_state    <= ST_RUN;
            r_flush    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pending[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (w_inc && !w_same && (dec_rd == 5'(i))) begin
                    r_pending[i] <= r_pending[i] + PEND_WIDTH'(1);
                end else if (w_dec_ok && (wb_rd == 5'(i))) begin
                    r_pending[i] <= r_pending[i] - PEND_WIDTH'(1);
                end
            end

            if (w_inc && !w_same && !w_dec_ok && (r_inflight != INF_MAX)) begin
                r_inflight <= r_inflight + INFLIGHT_WIDTH'(1);
            end else if (!w_inc && w_dec_ok && (r_inflight != '0)) begin
                r_inflight <= r_inflight - INFLIGHT_WIDTH'(1);
            end

            if (w_underflow) begin
                r_err <= 1'b1;
            end

            r_flush <= w_fire && dec_fence_i;

            case (r_state)
                ST_RUN: begin
                    if (w_fire && dec_fence_i) begin
                        r_state <= ST_FLUSH;
                    end else if (w_fire && dec_serialize) begin
                        r_state <= ST_SERIAL;
                    end
                end
                ST_SERIAL: begin
                    if (r_inflight == '0) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign inflight_count = r_inflight;
    assign fence_i_flush  = r_flush;
    assign err_underflow  = r_err;

endmodule
